// File: rtl/axi_err_drain.sv
// rtl/axi_err_drain.sv - autonomous drain of the AXI error unit pair into a record FIFO
//
// Purpose: when an error unit raises its interrupt, a reg-bus master reads the
// oldest stored error (address, code), pops it and pushes a record into a
// first-word-fall-through FIFO exposed as a valid/ready stream.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   enable_i           allows new drain sequences to start
//   err_irq_i[1:0]     [0] write-unit irq, [1] read-unit irq (level)
//   reg_req_o          reg-bus master request
//   reg_rsp_i          reg-bus response
//   rec_valid_o        record FIFO head valid
//   rec_ready_i        consumer accepts the head
//   rec_addr_o         logged error address
//   rec_code_o         raw error-code register word
//   rec_is_read_o      record came from the read unit
//   rec_bus_err_o      a reg access of the sequence returned error
//   fault_o            sticky: a pop write returned error
//   level_o            FIFO occupancy

package axi_err_drain_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

module axi_err_drain #(
    parameter int unsigned AddrWidth     = 32,
    parameter logic [31:0] BaseAddr      = 32'h0,
    parameter logic [31:0] ErrAddrOffset = 32'h00,
    parameter logic [31:0] ErrCodeOffset = 32'h08,
    parameter logic [31:0] PopOffset     = 32'h0C,
    parameter int unsigned FifoDepth     = 4,
    parameter type         reg_req_t     = axi_err_drain_pkg::reg_req_t,
    parameter type         reg_rsp_t     = axi_err_drain_pkg::reg_rsp_t
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         enable_i,
    input  logic [1:0]                   err_irq_i,
    output reg_req_t                     reg_req_o,
    input  reg_rsp_t                     reg_rsp_i,
    output logic                         rec_valid_o,
    input  logic                         rec_ready_i,
    output logic [AddrWidth-1:0]         rec_addr_o,
    output logic [31:0]                  rec_code_o,
    output logic                         rec_is_read_o,
    output logic                         rec_bus_err_o,
    output logic                         fault_o,
    output logic [$clog2(FifoDepth):0]   level_o
);

    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam int unsigned LvlW = PtrW + 1;
    localparam int unsigned RecW = AddrWidth + 32 + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_CODE,
        S_POP,
        S_PUSH
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_unit;
    logic                  r_last_read;
    logic [AddrWidth-1:0]  r_addr;
    logic [31:0]           r_code;
    logic                  r_err;
    logic                  r_fault;
    logic [RecW-1:0]       r_mem [FifoDepth];
    logic [PtrW-1:0]       r_wptr;
    logic [PtrW-1:0]       r_rptr;
    logic [LvlW-1:0]       r_level;

    logic                  w_full;
    logic                  w_start;
    logic                  w_sel;
    logic                  w_hs;
    logic                  w_push;
    logic                  w_pop;
    logic [31:0]           w_unit_base;

    assign w_full  = (r_level == LvlW'(FifoDepth));
    assign w_start = enable_i && (err_irq_i != 2'b00) && !w_full;
    // Both pending: serve the unit not served last; otherwise the lone requester.
    assign w_sel   = (err_irq_i == 2'b11) ? ~r_last_read : err_irq_i[1];
    assign w_unit_base = BaseAddr + (r_unit ? 32'h20 : 32'h0);
    assign w_hs    = reg_rsp_i.ready &&
                     (r_state == S_RD_ADDR || r_state == S_RD_CODE || r_state == S_POP);

    always_comb begin
        w_state_next = r_state;
        reg_req_o    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_next = S_RD_ADDR;
            end
            S_RD_ADDR: begin
                reg_req_o.valid = 1'b1;
                reg_req_o.addr  = w_unit_base + ErrAddrOffset;
                if (reg_rsp_i.ready) w_state_next = S_RD_CODE;
            end
            S_RD_CODE: begin
                reg_req_o.valid = 1'b1;
                reg_req_o.addr  = w_unit_base + ErrCodeOffset;
                if (reg_rsp_i.ready) w_state_next = S_POP;
            end
            S_POP: begin
                reg_req_o.valid = 1'b1;
                reg_req_o.addr  = w_unit_base + PopOffset;
                reg_req_o.write = 1'b1;
                reg_req_o.wstrb = '1;
                if (reg_rsp_i.ready) w_state_next = S_PUSH;
            end
            S_PUSH: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_unit      <= 1'b0;
            r_last_read <= 1'b1;
            r_addr      <= '0;
            r_code      <= '0;
            r_err       <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && w_start) begin
                r_unit      <= w_sel;
                r_last_read <= w_sel;
                r_err       <= 1'b0;
            end
            if (w_hs) begin
                r_err <= r_err | reg_rsp_i.error;
                if (r_state == S_RD_ADDR) r_addr <= reg_rsp_i.rdata[AddrWidth-1:0];
                if (r_state == S_RD_CODE) r_code <= reg_rsp_i.rdata;
                if (r_state == S_POP && reg_rsp_i.error) r_fault <= 1'b1;
            end
        end
    end

    // Record FIFO: space was checked before the sequence started, so a push
    // never meets a full FIFO.
    assign w_push      = (r_state == S_PUSH);
    assign rec_valid_o = (r_level != '0);
    assign w_pop       = rec_valid_o && rec_ready_i;

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= {r_addr, r_code, r_unit, r_err};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PtrW'(1);
            if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LvlW'(1);
                2'b01:   r_level <= r_level - LvlW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign {rec_addr_o, rec_code_o, rec_is_read_o, rec_bus_err_o} = r_mem[r_rptr];
    assign fault_o = r_fault;
    assign level_o = r_level;

endmodule
